clk_div_ctrl: RTL

Run-time controller for the design's programmable clock divider. It owns the divide counter, accepts new divisor values over a valid/ready handshake, and applies them only at a half-period boundary, so `clk_o` never has a runt pulse. Start and stop are also glitch-free: stopping always parks `clk_o` low on a clean edge. It sits between the control logic (e.g. sample-rate selection) and every consumer of the divided clock or its per-edge tick.

---
 rtl/clk_div_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: glitch-free start/stop and
// half-period-aligned divisor updates. Optional tick counter under `CLKDIV_TICKCNT_EN`.
module clk_div_ctrl #(
  parameter int          CNT_W   = 18,
  parameter int unsigned DEF_DIV = 250000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] div_o,
  output logic [15:0]      tick_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_q;
  logic             clk_q;
  logic             tick_q;
  logic             busy_q;
  logic             ready_q;

  // Handshake: a divisor transfers on any rising edge where cfg_valid_i and
  // cfg_ready_o are both high; ready is a registered decode of the state.
  logic             xfer;
  logic [CNT_W-1:0] cfg_clamped;
  logic             tc;
  logic             tick_d;

  assign xfer        = cfg_valid_i && ready_q;
  assign cfg_clamped = (cfg_div_i == '0) ? CNT_W'(1) : cfg_div_i;
  assign tc          = (cnt_q == div_q);
  assign tick_d      = (state_q != IDLE) && tc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN: begin
        if (xfer)           state_d = PEND;
        else if (!enable_i) state_d = STOP;
      end
      PEND: if (tc) state_d = enable_i ? RUN : STOP;
      STOP: begin
        if (enable_i)        state_d = RUN;
        else if (tc && clk_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF_DIV_W;
      pend_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE) || (state_d == RUN);
      tick_q  <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
        if (xfer) div_q <= cfg_clamped;
      end else begin
        if (tc) begin
          cnt_q  <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (state_q == RUN && xfer) pend_q <= cfg_clamped;
        // The pending value takes effect only once the old half period has ended.
        if (state_q == PEND && tc) div_q <= pend_q;
      end
    end
  end

`ifdef CLKDIV_TICKCNT_EN
  logic [15:0] tick_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       tick_cnt_q <= '0;
    else if (tick_d) tick_cnt_q <= tick_cnt_q + 16'd1;
  end

  assign tick_cnt_o = tick_cnt_q;
`else
  logic unused_tick;
  assign unused_tick = tick_d;
  assign tick_cnt_o  = '0;
`endif

  assign cfg_ready_o = ready_q;
  assign clk_o       = clk_q;
  assign tick_o      = tick_q;
  assign busy_o      = busy_q;
  assign div_o       = div_q;
  assign state_o     = state_q;

endmodule
